multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter ILLEGAL_TRAP, default 1: 1 = unknown instruction halts the core; 0 = it executes as nop.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port opcode, input, 6, instr[31:26] from the instruction-field decoder.
REQ-005 SHALL have port func, input, 6, instr[5:0] from the same decoder.
REQ-006 SHALL have port zero, input, 1, ALU equality flag, sampled in BRANCH only.
REQ-007 SHALL have port mem_ready, input, 1, memory completion for the current read or write.
REQ-008 SHALL have outputs pc_we (1), ir_we (1), reg_we (1), mem_re (1) and mem_we (1): write/read strobes, each one cycle unless stalled.
REQ-009 SHALL have outputs npc_sel (2: 0 = PC+4, 1 = branch, 2 = jump index, 3 = rs), reg_dst (2: 0 = rt, 1 = rd, 2 = r31), wd_sel (2: 0 = ALU, 1 = memory, 2 = PC+4) and alu_src (1: 0 = rt, 1 = extended imm).
REQ-010 SHALL have outputs alu_op (3: 0 = add, 1 = sub, 2 = or, 3 = lui) and ext_op (2: 0 = zero-extend, 1 = sign-extend, 2 = upper).
REQ-011 SHALL have outputs halted (1), sticky after a trapped illegal instruction, and state (4), the current state for debug.

Function
REQ-012 SHALL support addu, subu, jr (opcode 0), ori, lui, lw, sw, beq, j and jal; sll with func 0 and shamt 0 counts as nop.
REQ-013 SHALL have FSM states FETCH, DECODE, EXE, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP and HALT.
REQ-014 FETCH SHALL assert mem_re; while mem_ready = 0 it holds with all write strobes at 0; on mem_ready = 1 it asserts ir_we and pc_we (npc_sel = 0) in that cycle and goes to DECODE.
REQ-015 DECODE SHALL classify opcode/func and branch: R-type/ori/lui to EXE; lw/sw to EXE; beq to BRANCH; j/jal/jr to JUMP; nop to FETCH; illegal to HALT if ILLEGAL_TRAP = 1, else to FETCH.
REQ-016 EXE SHALL drive alu_op, alu_src and ext_op per instruction (lw/sw: add, imm, sign; ori: or, imm, zero; lui: lui, imm, upper), then go to WB_ALU, MEM_RD (lw) or MEM_WR (sw).
REQ-017 MEM_RD and MEM_WR SHALL hold mem_re or mem_we until mem_ready = 1; MEM_RD then goes to WB_MEM and MEM_WR to FETCH.
REQ-018 WB_ALU and WB_MEM SHALL assert reg_we for exactly one cycle (reg_dst = 1 for R-type, else 0) and return to FETCH.
REQ-019 BRANCH SHALL drive alu_op = sub and assert pc_we with npc_sel = 1 only if zero = 1; it then returns to FETCH.
REQ-020 JUMP SHALL assert pc_we (npc_sel = 2 for j/jal, 3 for jr); jal also asserts reg_we with reg_dst = 2 and wd_sel = 2 in the same cycle; it then goes to FETCH.
REQ-021 Cycle counts with zero-wait memory SHALL be: branch/jump 3, ALU 4, sw 4, lw 5.
REQ-022 HALT SHALL be absorbing: all strobes 0 and halted = 1 until reset.
REQ-023 All strobes SHALL be Moore outputs decoded from the state and the latched opcode/func; opcode/func SHALL be latched in DECODE, so inputs changing later have no effect.
REQ-024 pc_we, reg_we and mem_we SHALL never be asserted while mem_ready = 0 in a memory-wait state.

Reset
REQ-025 rst_n = 0 SHALL immediately force state FETCH, all strobes 0, all selects 0 and halted 0, including in mid-instruction or in HALT.
REQ-026 After reset release, the first rising edge SHALL already evaluate FETCH.

Structure
REQ-027 Opcode/func constants, the state encoding, and the alu_op/ext_op/npc_sel/reg_dst/wd_sel codes SHALL live in shared package mips_ctrl_pkg.
REQ-028 Instruction classification SHALL be a combinational sub-module ctrl_class that maps opcode/func to a one-hot class plus an illegal flag; the FSM lives in multicycle_ctrl.

Verification
REQ-029 addu (opcode 0, func 0x21), mem_ready = 1 -> states FETCH, DECODE, EXE, WB_ALU; reg_we = 1 for one cycle in cycle 4 with reg_dst = 1; pc_we = 1 in cycle 1 only.
REQ-030 lw (0x23) with mem_ready low for 3 cycles in MEM_RD -> mem_re held 4 cycles; WB_MEM reg_we = 1 with wd_sel = 1; 8 cycles total.
REQ-031 beq (0x04) with zero = 0 -> no pc_we in BRANCH; with zero = 1 -> pc_we = 1 with npc_sel = 1.
REQ-032 jal (0x03) -> in JUMP, pc_we = 1, npc_sel = 2, reg_we = 1, reg_dst = 2, wd_sel = 2, in the same cycle.
REQ-033 Opcode 0x3F with ILLEGAL_TRAP = 1 -> HALT, halted = 1, no strobes for 20 cycles; with ILLEGAL_TRAP = 0 -> back to FETCH after DECODE.
REQ-034 rst_n pulsed low during MEM_WR -> mem_we drops asynchronously, state = FETCH, and execution restarts cleanly.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: opcodes,
// function codes, FSM states, datapath select codes and instruction classes.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXE    = 4'd2,
    S_MEM_RD = 4'd3,
    S_MEM_WR = 4'd4,
    S_WB_ALU = 4'd5,
    S_WB_MEM = 4'd6,
    S_BRANCH = 4'd7,
    S_JUMP   = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  typedef enum logic [2:0] {ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_OR = 3'd2, ALU_LUI = 3'd3} alu_op_t;
  typedef enum logic [1:0] {EXT_ZERO = 2'd0, EXT_SIGN = 2'd1, EXT_UPPER = 2'd2} ext_op_t;
  typedef enum logic [1:0] {NPC_PC4 = 2'd0, NPC_BRANCH = 2'd1, NPC_JIDX = 2'd2, NPC_RS = 2'd3} npc_sel_t;
  typedef enum logic [1:0] {DST_RT = 2'd0, DST_RD = 2'd1, DST_R31 = 2'd2} reg_dst_t;
  typedef enum logic [1:0] {WD_ALU = 2'd0, WD_MEM = 2'd1, WD_PC4 = 2'd2} wd_sel_t;

  // One-hot instruction class bit positions
  localparam int C_ADDU  = 0;
  localparam int C_SUBU  = 1;
  localparam int C_ORI   = 2;
  localparam int C_LUI   = 3;
  localparam int C_LW    = 4;
  localparam int C_SW    = 5;
  localparam int C_BEQ   = 6;
  localparam int C_J     = 7;
  localparam int C_JAL   = 8;
  localparam int C_JR    = 9;
  localparam int C_NOP   = 10;
  localparam int NUM_CLS = 11;

  typedef logic [NUM_CLS-1:0] cls_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: decoded instruction fields and flags in,
// strobes and selects out. master = controller, slave = datapath.
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       zero;
  logic       mem_ready;
  logic       pc_we;
  logic       ir_we;
  logic       reg_we;
  logic       mem_re;
  logic       mem_we;
  logic [1:0] npc_sel;
  logic [1:0] reg_dst;
  logic [1:0] wd_sel;
  logic       alu_src;
  logic [2:0] alu_op;
  logic [1:0] ext_op;
  logic       halted;
  logic [3:0] state;

  modport master (
    input  opcode, func, zero, mem_ready,
    output pc_we, ir_we, reg_we, mem_re, mem_we,
           npc_sel, reg_dst, wd_sel, alu_src, alu_op, ext_op, halted, state
  );

  modport slave (
    output opcode, func, zero, mem_ready,
    input  pc_we, ir_we, reg_we, mem_re, mem_we,
           npc_sel, reg_dst, wd_sel, alu_src, alu_op, ext_op, halted, state
  );
endinterface

// File: rtl/multicycle_ctrl_class.sv
// Combinational instruction classifier: opcode/func -> one-hot class,
// with illegal raised when nothing matches.
module ctrl_class
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output cls_t       cls,
  output logic       illegal
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_RTYPE: begin
        case (func)
          FN_ADDU: cls[C_ADDU] = 1'b1;
          FN_SUBU: cls[C_SUBU] = 1'b1;
          FN_JR:   cls[C_JR]   = 1'b1;
          // shamt is not visible here; any sll is treated as nop
          FN_SLL:  cls[C_NOP]  = 1'b1;
          default: ;
        endcase
      end
      OP_ORI:  cls[C_ORI] = 1'b1;
      OP_LUI:  cls[C_LUI] = 1'b1;
      OP_LW:   cls[C_LW]  = 1'b1;
      OP_SW:   cls[C_SW]  = 1'b1;
      OP_BEQ:  cls[C_BEQ] = 1'b1;
      OP_J:    cls[C_J]   = 1'b1;
      OP_JAL:  cls[C_JAL] = 1'b1;
      default: ;
    endcase
  end

  assign illegal = (cls == '0);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM. Strobes decode from the state and the
// opcode/func latched in DECODE; only FETCH/MEM waits and BRANCH look at live flags.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int ILLEGAL_TRAP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus
);

  state_t     state_q, state_d;
  logic [5:0] op_q, fn_q;
  logic [5:0] op_cls, fn_cls;
  cls_t       cls;
  logic       illegal;

  logic       pc_we, ir_we, reg_we, mem_re, mem_we, alu_src, halted;
  npc_sel_t   npc_sel;
  reg_dst_t   reg_dst;
  wd_sel_t    wd_sel;
  alu_op_t    alu_op;
  ext_op_t    ext_op;

  // DECODE classifies the live fields; every later state uses the latched copy
  assign op_cls = (state_q == S_DECODE) ? bus.opcode : op_q;
  assign fn_cls = (state_q == S_DECODE) ? bus.func   : fn_q;

  ctrl_class u_class (
    .opcode  (op_cls),
    .func    (fn_cls),
    .cls     (cls),
    .illegal (illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      fn_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= bus.opcode;
        fn_q <= bus.func;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pc_we   = 1'b0;
    ir_we   = 1'b0;
    reg_we  = 1'b0;
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    alu_src = 1'b0;
    halted  = 1'b0;
    npc_sel = NPC_PC4;
    reg_dst = DST_RT;
    wd_sel  = WD_ALU;
    alu_op  = ALU_ADD;
    ext_op  = EXT_ZERO;

    case (state_q)
      S_FETCH: begin
        mem_re = 1'b1;
        if (bus.mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (cls[C_ADDU] | cls[C_SUBU] | cls[C_ORI] | cls[C_LUI] | cls[C_LW] | cls[C_SW])
          state_d = S_EXE;
        else if (cls[C_BEQ])
          state_d = S_BRANCH;
        else if (cls[C_J] | cls[C_JAL] | cls[C_JR])
          state_d = S_JUMP;
        else if (cls[C_NOP])
          state_d = S_FETCH;
        else if (illegal && ILLEGAL_TRAP != 0)
          state_d = S_HALT;
        else
          state_d = S_FETCH;
      end
      S_EXE: begin
        if (cls[C_ADDU] | cls[C_SUBU]) begin
          alu_op = cls[C_SUBU] ? ALU_SUB : ALU_ADD;
        end else begin
          alu_src = 1'b1;
          if (cls[C_ORI]) begin
            alu_op = ALU_OR;
            ext_op = EXT_ZERO;
          end else if (cls[C_LUI]) begin
            alu_op = ALU_LUI;
            ext_op = EXT_UPPER;
          end else begin
            alu_op = ALU_ADD;
            ext_op = EXT_SIGN;
          end
        end
        if (cls[C_LW])      state_d = S_MEM_RD;
        else if (cls[C_SW]) state_d = S_MEM_WR;
        else                state_d = S_WB_ALU;
      end
      S_MEM_RD: begin
        mem_re = 1'b1;
        if (bus.mem_ready) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        // write enable is qualified by ready so no store fires into a busy memory
        if (bus.mem_ready) begin
          mem_we  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_WB_ALU: begin
        reg_we  = 1'b1;
        reg_dst = (cls[C_ADDU] | cls[C_SUBU]) ? DST_RD : DST_RT;
        state_d = S_FETCH;
      end
      S_WB_MEM: begin
        reg_we  = 1'b1;
        wd_sel  = WD_MEM;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_op  = ALU_SUB;
        npc_sel = NPC_BRANCH;
        pc_we   = bus.zero;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_we   = 1'b1;
        npc_sel = cls[C_JR] ? NPC_RS : NPC_JIDX;
        if (cls[C_JAL]) begin
          reg_we  = 1'b1;
          reg_dst = DST_R31;
          wd_sel  = WD_PC4;
        end
        state_d = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset blanks outputs immediately, even though FETCH would otherwise drive mem_re
    if (!rst_n) begin
      pc_we   = 1'b0;
      ir_we   = 1'b0;
      reg_we  = 1'b0;
      mem_re  = 1'b0;
      mem_we  = 1'b0;
      alu_src = 1'b0;
      halted  = 1'b0;
      npc_sel = NPC_PC4;
      reg_dst = DST_RT;
      wd_sel  = WD_ALU;
      alu_op  = ALU_ADD;
      ext_op  = EXT_ZERO;
    end
  end

  assign bus.pc_we   = pc_we;
  assign bus.ir_we   = ir_we;
  assign bus.reg_we  = reg_we;
  assign bus.mem_re  = mem_re;
  assign bus.mem_we  = mem_we;
  assign bus.npc_sel = npc_sel;
  assign bus.reg_dst = reg_dst;
  assign bus.wd_sel  = wd_sel;
  assign bus.alu_src = alu_src;
  assign bus.alu_op  = alu_op;
  assign bus.ext_op  = ext_op;
  assign bus.halted  = halted;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by
// cycle, plus stalls, reset mid-store and illegal trap/no-trap variants.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] func = 6'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  int         checks = 0;
  int         errors = 0;

  localparam logic [4:0] FGO   = 5'b11010; // {pc_we, ir_we, reg_we, mem_re, mem_we}
  localparam logic [4:0] FWAIT = 5'b00010;
  localparam logic [4:0] NONE  = 5'b00000;
  localparam logic [4:0] REGW  = 5'b00100;
  localparam logic [4:0] MRE   = 5'b00010;
  localparam logic [4:0] MWE   = 5'b00001;
  localparam logic [4:0] PCW   = 5'b10000;
  localparam logic [4:0] PCREG = 5'b10100;

  multicycle_ctrl_if bus1();
  multicycle_ctrl_if bus0();

  assign bus1.opcode = opcode;    assign bus0.opcode = opcode;
  assign bus1.func = func;        assign bus0.func = func;
  assign bus1.zero = zero;        assign bus0.zero = zero;
  assign bus1.mem_ready = mem_ready; assign bus0.mem_ready = mem_ready;

  multicycle_ctrl #(.ILLEGAL_TRAP(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  multicycle_ctrl #(.ILLEGAL_TRAP(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  always #5 clk = ~clk;

  wire [4:0] strb1 = {bus1.pc_we, bus1.ir_we, bus1.reg_we, bus1.mem_re, bus1.mem_we};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic look(input string tag, input logic [3:0] st, input logic [4:0] sb);
    #1;
    chk({tag, ".state"}, 32'(bus1.state), 32'(st));
    chk({tag, ".strb"}, 32'(strb1), 32'(sb));
  endtask

  // FETCH (zero-wait) followed by DECODE for one instruction
  task automatic fd(input string tag, input logic [5:0] op, input logic [5:0] fn);
    @(negedge clk);
    opcode = op; func = fn; mem_ready = 1'b1;
    look({tag, ".f"}, 4'd0, FGO);
    @(negedge clk);
    look({tag, ".d"}, 4'd1, NONE);
  endtask

  initial begin
    // reset state
    look("reset", 4'd0, NONE);
    chk("reset.halted", 32'(bus1.halted), 0);
    chk("reset.sels", 32'({bus1.npc_sel, bus1.reg_dst, bus1.wd_sel, bus1.alu_src, bus1.alu_op, bus1.ext_op}), 0);
    chk("reset.dut0", 32'(bus0.state), 0);

    // addu: release before the first edge, which already evaluates FETCH
    rst_n = 1'b1; opcode = 6'h00; func = 6'h21;
    look("addu.f", 4'd0, FGO);
    @(negedge clk); look("addu.d", 4'd1, NONE);
    @(negedge clk); look("addu.x", 4'd2, NONE);
    chk("addu.alu_op", 32'(bus1.alu_op), 0);
    chk("addu.alu_src", 32'(bus1.alu_src), 0);
    @(negedge clk); look("addu.wb", 4'd5, REGW);
    chk("addu.reg_dst", 32'(bus1.reg_dst), 1);
    chk("addu.wd_sel", 32'(bus1.wd_sel), 0);

    // subu: func changes after DECODE must be ignored
    fd("subu", 6'h00, 6'h23);
    @(negedge clk); func = 6'h21; look("subu.x", 4'd2, NONE);
    chk("subu.alu_op", 32'(bus1.alu_op), 1);
    @(negedge clk); look("subu.wb", 4'd5, REGW);
    chk("subu.reg_dst", 32'(bus1.reg_dst), 1);

    // FETCH stall then ori
    @(negedge clk); opcode = 6'h0D; mem_ready = 1'b0;
    look("stall.f", 4'd0, FWAIT);
    fd("ori", 6'h0D, 6'h00);
    @(negedge clk); look("ori.x", 4'd2, NONE);
    chk("ori.alu_op", 32'(bus1.alu_op), 2);
    chk("ori.alu_src", 32'(bus1.alu_src), 1);
    chk("ori.ext_op", 32'(bus1.ext_op), 0);
    @(negedge clk); look("ori.wb", 4'd5, REGW);
    chk("ori.reg_dst", 32'(bus1.reg_dst), 0);

    // lui
    fd("lui", 6'h0F, 6'h00);
    @(negedge clk); look("lui.x", 4'd2, NONE);
    chk("lui.alu_op", 32'(bus1.alu_op), 3);
    chk("lui.ext_op", 32'(bus1.ext_op), 2);
    @(negedge clk); look("lui.wb", 4'd5, REGW);

    // lw with three wait cycles: 8 cycles total
    fd("lw", 6'h23, 6'h00);
    @(negedge clk); look("lw.x", 4'd2, NONE);
    chk("lw.alu_op", 32'(bus1.alu_op), 0);
    chk("lw.ext_op", 32'(bus1.ext_op), 1);
    chk("lw.alu_src", 32'(bus1.alu_src), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_ready = 1'b0; look("lw.wait", 4'd3, MRE);
    end
    @(negedge clk); mem_ready = 1'b1; look("lw.rd", 4'd3, MRE);
    @(negedge clk); look("lw.wb", 4'd6, REGW);
    chk("lw.wd_sel", 32'(bus1.wd_sel), 1);
    chk("lw.reg_dst", 32'(bus1.reg_dst), 0);

    // sw with one wait cycle: no mem_we while not ready
    fd("sw", 6'h2B, 6'h00);
    @(negedge clk); look("sw.x", 4'd2, NONE);
    chk("sw.ext_op", 32'(bus1.ext_op), 1);
    @(negedge clk); mem_ready = 1'b0; look("sw.wait", 4'd4, NONE);
    @(negedge clk); mem_ready = 1'b1; look("sw.wr", 4'd4, MWE);

    // beq not taken / taken
    fd("beq0", 6'h04, 6'h00);
    @(negedge clk); zero = 1'b0; look("beq0.br", 4'd7, NONE);
    chk("beq0.alu_op", 32'(bus1.alu_op), 1);
    fd("beq1", 6'h04, 6'h00);
    @(negedge clk); zero = 1'b1; look("beq1.br", 4'd7, PCW);
    chk("beq1.npc_sel", 32'(bus1.npc_sel), 1);
    zero = 1'b0;

    // j, jal, jr
    fd("j", 6'h02, 6'h00);
    @(negedge clk); look("j.jmp", 4'd8, PCW);
    chk("j.npc_sel", 32'(bus1.npc_sel), 2);
    fd("jal", 6'h03, 6'h00);
    @(negedge clk); look("jal.jmp", 4'd8, PCREG);
    chk("jal.npc_sel", 32'(bus1.npc_sel), 2);
    chk("jal.reg_dst", 32'(bus1.reg_dst), 2);
    chk("jal.wd_sel", 32'(bus1.wd_sel), 2);
    fd("jr", 6'h00, 6'h08);
    @(negedge clk); look("jr.jmp", 4'd8, PCW);
    chk("jr.npc_sel", 32'(bus1.npc_sel), 3);

    // nop returns straight to FETCH, which fetches a sw
    fd("nop", 6'h00, 6'h00);
    @(negedge clk); opcode = 6'h2B; look("nop.back", 4'd0, FGO);
    @(negedge clk); look("sw2.d", 4'd1, NONE);
    @(negedge clk); look("sw2.x", 4'd2, NONE);
    @(negedge clk); look("sw2.wr", 4'd4, MWE);

    // reset pulse mid-store: mem_we drops without a clock edge
    #1; rst_n = 1'b0;
    #1;
    chk("rst.mem_we", 32'(bus1.mem_we), 0);
    chk("rst.state", 32'(bus1.state), 0);
    chk("rst.strb", 32'(strb1), 0);
    #1; rst_n = 1'b1; opcode = 6'h00; func = 6'h21;
    @(negedge clk); look("rst.d", 4'd1, NONE);
    @(negedge clk); look("rst.x", 4'd2, NONE);
    @(negedge clk); look("rst.wb", 4'd5, REGW);
    chk("rst.reg_dst", 32'(bus1.reg_dst), 1);

    // illegal opcode: trap halts dut1, dut0 falls back to FETCH
    fd("ill", 6'h3F, 6'h00);
    chk("ill.d.dut0", 32'(bus0.state), 1);
    @(negedge clk); look("ill.halt", 4'd9, NONE);
    chk("ill.halted", 32'(bus1.halted), 1);
    chk("ill.dut0.state", 32'(bus0.state), 0);
    chk("ill.dut0.halted", 32'(bus0.halted), 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      opcode = 6'(i * 5); func = 6'h21; mem_ready = i[0]; zero = i[1];
      #1;
      chk("halt.state", 32'(bus1.state), 9);
      chk("halt.strb", 32'(strb1), 0);
      chk("halt.halted", 32'(bus1.halted), 1);
    end
    #1; rst_n = 1'b0;
    #1;
    chk("halt.rst.state", 32'(bus1.state), 0);
    chk("halt.rst.halted", 32'(bus1.halted), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
